// File: rtl/topo_spawn_scheduler.sv
// topo_spawn_scheduler
// Paces the whack-a-mole game: a fixed gap, a one-cycle spawn strobe carrying
// the cell number, then a visible window whose length shrinks with the level.
// A window that expires without a hit raises a one-cycle miss strobe and bumps
// a saturating miss counter.
// Optional feature macro: AVOID_REPEAT_EN -- when defined, a spawn never reuses
// the previous cell (a repeat is bumped to (iRand+1) mod 16).
module topo_spawn_scheduler #(
  parameter int TICK_DIV  = 25000,
  parameter int GAP_MS    = 500,
  parameter int WINDOW_MS = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iEnable,
  input  logic [2:0] iLevel,
  input  logic [3:0] iRand,
  input  logic       iHit,
  output logic       oPonerTopo,
  output logic [3:0] oCelda,
  output logic       oActive,
  output logic       oMiss,
  output logic [7:0] oMissCount
);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_SPAWN, S_ACTIVE} state_t;

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0]     GAP_LAST  = 16'(GAP_MS - 1);
  localparam logic [15:0]     WIN_BASE  = 16'(WINDOW_MS);

  state_t         r_state;
  state_t         w_next;
  logic [PW-1:0]  r_presc;
  logic [15:0]    r_tick;
  logic [15:0]    r_window;
  logic           r_hit_d;
  logic           r_miss;
  logic [3:0]     r_celda;
  logic [7:0]     r_miss_cnt;

  logic           w_tick_wrap;
  logic           w_gap_done;
  logic           w_win_done;
  logic           w_hit_rise;
  logic           w_expire_miss;
  logic [2:0]     w_lvl;
  logic [2:0]     w_shift;
  logic [15:0]    w_win_shift;
  logic [15:0]    w_window_calc;
  logic [3:0]     w_celda_next;

  assign w_tick_wrap = (r_presc == PRESC_MAX);
  assign w_gap_done  = w_tick_wrap && (r_tick == GAP_LAST);
  assign w_win_done  = w_tick_wrap && (r_tick == r_window - 16'd1);
  assign w_hit_rise  = iHit & ~r_hit_d;

  // Window length for the current level: clamp to 1..5, halve per level, floor at 1 tick.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    w_lvl = iLevel;
    if (iLevel == 3'd0)      w_lvl = 3'd1;
    else if (iLevel > 3'd5)  w_lvl = 3'd5;
    w_shift       = w_lvl - 3'd1;
    w_win_shift   = WIN_BASE >> w_shift;
    w_window_calc = (w_win_shift == 16'd0) ? 16'd1 : w_win_shift;
  end

  // Cell to latch at spawn time.
`ifdef AVOID_REPEAT_EN
  assign w_celda_next = (iRand == r_celda) ? iRand + 4'd1 : iRand;
`else
  assign w_celda_next = iRand;
`endif

  // State register.
  always_ff @(posedge Clock) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; disable wins over everything, a hit wins over expiry.
  always_comb begin
    w_next        = r_state;
    w_expire_miss = 1'b0;
    if (!iEnable) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   w_next = S_GAP;
        S_GAP:    if (w_gap_done) w_next = S_SPAWN;
        S_SPAWN:  w_next = S_ACTIVE;
        S_ACTIVE: begin
          if (w_hit_rise) begin
            w_next = S_GAP;
          end else if (w_win_done) begin
            w_next        = S_GAP;
            w_expire_miss = 1'b1;
          end
        end
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Timebase: prescaler and tick counter restart on every state change so GAP and ACTIVE are exact.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_presc <= '0;
      r_tick  <= '0;
    end else if (w_next != r_state) begin
      r_presc <= '0;
      r_tick  <= '0;
    end else if (r_state == S_GAP || r_state == S_ACTIVE) begin
      if (w_tick_wrap) begin
        r_presc <= '0;
        r_tick  <= r_tick + 16'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Hit edge history, miss strobe/counter, spawn cell and latched window length.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_hit_d    <= 1'b0;
      r_miss     <= 1'b0;
      r_miss_cnt <= 8'd0;
      r_celda    <= 4'd0;
      r_window   <= 16'd1;
    end else begin
      r_hit_d <= iHit;
      r_miss  <= w_expire_miss;
      if (w_expire_miss && r_miss_cnt != 8'hFF)
        r_miss_cnt <= r_miss_cnt + 8'd1;
      if (r_state == S_GAP && w_next == S_SPAWN)
        r_celda <= w_celda_next;
      if (r_state == S_SPAWN && w_next == S_ACTIVE)
        r_window <= w_window_calc;
    end
  end

  assign oPonerTopo = (r_state == S_SPAWN);
  assign oActive    = (r_state == S_ACTIVE);
  assign oMiss      = r_miss;
  assign oCelda     = r_celda;
  assign oMissCount = r_miss_cnt;

endmodule

// File: tb/tb_topo_spawn_scheduler.sv
// Self-checking bench for topo_spawn_scheduler (TICK_DIV=4, GAP_MS=3, WINDOW_MS=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_topo_spawn_scheduler;

  localparam int TD  = 4;
  localparam int GAP = 3;
  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       Reset;
  logic       iEnable;
  logic [2:0] iLevel;
  logic [3:0] iRand;
  logic       iHit;
  logic       oPonerTopo;
  logic [3:0] oCelda;
  logic       oActive;
  logic       oMiss;
  logic [7:0] oMissCount;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_cnt  = 0;
  logic [3:0]  m_prev = 4'd0;

  topo_spawn_scheduler #(.TICK_DIV(TD), .GAP_MS(GAP), .WINDOW_MS(WIN)) dut (
    .Clock      (clk),
    .Reset      (Reset),
    .iEnable    (iEnable),
    .iLevel     (iLevel),
    .iRand      (iRand),
    .iHit       (iHit),
    .oPonerTopo (oPonerTopo),
    .oCelda     (oCelda),
    .oActive    (oActive),
    .oMiss      (oMiss),
    .oMissCount (oMissCount)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int lvl;
    int rnd;
    int hit_at;
    bit keep;
    int len;
    int miss;
    int c_plain;
    int c_avoid;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference cell choice.
  function automatic logic [3:0] model_celda(input logic [3:0] r, input logic [3:0] prev);
`ifdef AVOID_REPEAT_EN
    return (r == prev) ? r + 4'd1 : r;
`else
    return r;
`endif
  endfunction

  // Reference window length in cycles for a raw level input.
  function automatic int model_window(input int lvl_raw);
    int lvl;
    int w;
    lvl = (lvl_raw < 1) ? 1 : (lvl_raw > 5) ? 5 : lvl_raw;
    w   = WIN / (1 << (lvl - 1));
    if (w < 1) w = 1;
    return w * TD;
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  // Steps until a spawn strobe is seen; n=-1 on timeout. Counts miss strobes seen along the way.
  task automatic wait_spawn(output int n, output int miss_seen);
    n = 0;
    miss_seen = 0;
    do begin
      step();
      n++;
      if (oMiss) miss_seen++;
    end while (!oPonerTopo && n < 1000);
    if (!oPonerTopo) n = -1;
  endtask

  // Called on the spawn cycle: measures the active window, optionally raising a hit.
  task automatic run_active(input int hit_at, input int new_lvl, output int len, output int miss);
    len = 0;
    step();
    while (oActive && len < 2000) begin
      len++;
      if (len == 1 && new_lvl >= 0) iLevel = 3'(new_lvl);
      if (len == hit_at) iHit = 1'b1;
      step();
    end
    miss = int'(oMiss);
  endtask

  initial begin
    int n, ms, len, miss, exp_c, total;

    tbl[0]  = '{3, 3,  0, 1'b0, 16, 1, 3,  3};
    tbl[1]  = '{5, 9,  0, 1'b0, 4,  1, 9,  9};
    tbl[2]  = '{0, 2,  0, 1'b0, 64, 1, 2,  2};
    tbl[3]  = '{7, 5,  0, 1'b0, 4,  1, 5,  5};
    tbl[4]  = '{2, 11, 5, 1'b0, 5,  0, 11, 11};
    tbl[5]  = '{4, 11, 0, 1'b1, 8,  1, 11, 12};
    tbl[6]  = '{4, 12, 8, 1'b0, 8,  0, 12, 13};
    tbl[7]  = '{3, 7,  0, 1'b0, 16, 1, 7,  7};
    tbl[8]  = '{5, 7,  0, 1'b0, 4,  1, 7,  8};
    tbl[9]  = '{5, 15, 0, 1'b0, 4,  1, 15, 15};
    tbl[10] = '{5, 15, 0, 1'b0, 4,  1, 15, 0};
    tbl[11] = '{5, 0,  0, 1'b0, 4,  1, 0,  1};
    tbl[12] = '{1, 4,  1, 1'b0, 1,  0, 4,  4};

    // Reset state
    Reset = 1'b1; iEnable = 1'b0; iLevel = 3'd1; iRand = 4'd0; iHit = 1'b0;
    step(); step();
    check("rst_poner",  int'(oPonerTopo), 0);
    check("rst_active", int'(oActive),    0);
    check("rst_miss",   int'(oMiss),      0);
    check("rst_celda",  int'(oCelda),     0);
    check("rst_count",  int'(oMissCount), 0);
    Reset = 1'b0;
    step();

    // Level 1 window with no hit
    iEnable = 1'b1; iLevel = 3'd1; iRand = 4'd7;
    wait_spawn(n, ms);
    check("s1_spawn_delay", n, 1 + GAP * TD);
    check("s1_celda", int'(oCelda), 7);
    m_prev = 4'd7;
    run_active(0, -1, len, miss);
    check("s1_active_len", len, 64);
    check("s1_miss", miss, 1);
    m_cnt = sat_inc(m_cnt);
    check("s1_count", int'(oMissCount), m_cnt);

    // Table-driven windows
    foreach (tbl[i]) begin
      iLevel = 3'(tbl[i].lvl);
      iRand  = 4'(tbl[i].rnd);
      if (!tbl[i].keep) iHit = 1'b0;
      wait_spawn(n, ms);
      check($sformatf("t%0d_gap", i), n, GAP * TD);
      check($sformatf("t%0d_miss_in_gap", i), ms, 0);
`ifdef AVOID_REPEAT_EN
      exp_c = tbl[i].c_avoid;
`else
      exp_c = tbl[i].c_plain;
`endif
      check($sformatf("t%0d_celda", i), int'(oCelda), exp_c);
      m_prev = 4'(exp_c);
      run_active(tbl[i].hit_at, -1, len, miss);
      check($sformatf("t%0d_len", i), len, tbl[i].len);
      check($sformatf("t%0d_miss", i), miss, tbl[i].miss);
      if (tbl[i].miss != 0) m_cnt = sat_inc(m_cnt);
      check($sformatf("t%0d_count", i), int'(oMissCount), m_cnt);
    end
    iHit = 1'b0;

    // Disable mid-GAP
    repeat (4) step();
    iEnable = 1'b0;
    step();
    check("dis_gap_active", int'(oActive), 0);
    n = 0;
    repeat (30) begin
      step();
      if (oPonerTopo || oMiss || oActive) n++;
    end
    check("dis_gap_quiet", n, 0);
    check("dis_gap_celda", int'(oCelda), int'(m_prev));
    check("dis_gap_count", int'(oMissCount), m_cnt);
    iRand = 4'd9; iLevel = 3'd1;
    iEnable = 1'b1;
    wait_spawn(n, ms);
    check("reen_gap_delay", n, 1 + GAP * TD);
    exp_c = int'(model_celda(4'd9, m_prev));
    check("reen_gap_celda", int'(oCelda), exp_c);
    m_prev = 4'(exp_c);

    // Disable mid-ACTIVE
    repeat (10) step();
    check("dis_act_was_active", int'(oActive), 1);
    iEnable = 1'b0;
    step();
    check("dis_act_active", int'(oActive), 0);
    n = 0;
    repeat (80) begin
      step();
      if (oPonerTopo || oMiss || oActive) n++;
    end
    check("dis_act_quiet", n, 0);
    check("dis_act_count", int'(oMissCount), m_cnt);
    iRand = 4'd6;
    iEnable = 1'b1;
    wait_spawn(n, ms);
    check("reen_act_delay", n, 1 + GAP * TD);
    exp_c = int'(model_celda(4'd6, m_prev));
    check("reen_act_celda", int'(oCelda), exp_c);
    m_prev = 4'(exp_c);
    run_active(0, -1, len, miss);
    check("reen_act_len", len, 64);
    check("reen_act_miss", miss, 1);
    m_cnt = sat_inc(m_cnt);

    // Randomized windows against the reference model
    for (int k = 0; k < 40; k++) begin
      int  lvl, rnd, win, hit_at, exp_len, exp_miss;
      bit  keep;
      lvl    = int'($urandom_range(7));
      rnd    = int'($urandom_range(15));
      win    = model_window(lvl);
      hit_at = int'($urandom_range(win + 2));
      keep   = ($urandom_range(3) == 0);
      iLevel = 3'(lvl);
      iRand  = 4'(rnd);
      iHit   = keep;
      if (keep || hit_at == 0 || hit_at > win) begin
        exp_len  = win;
        exp_miss = 1;
      end else begin
        exp_len  = hit_at;
        exp_miss = 0;
      end
      wait_spawn(n, ms);
      check($sformatf("r%0d_gap", k), n, GAP * TD);
      exp_c = int'(model_celda(4'(rnd), m_prev));
      check($sformatf("r%0d_celda", k), int'(oCelda), exp_c);
      m_prev = 4'(exp_c);
      run_active(hit_at, int'($urandom_range(7)), len, miss);
      check($sformatf("r%0d_len", k), len, exp_len);
      check($sformatf("r%0d_miss", k), miss, exp_miss);
      if (exp_miss != 0) m_cnt = sat_inc(m_cnt);
      check($sformatf("r%0d_count", k), int'(oMissCount), m_cnt);
    end
    iHit = 1'b0;

    // Saturation after 300 misses
    iLevel = 3'd5;
    total = 0;
    for (int k = 0; k < 300; k++) begin
      iRand = 4'(k);
      wait_spawn(n, ms);
      run_active(0, -1, len, miss);
      total += miss;
    end
    check("sat_misses", total, 300);
    check("sat_count", int'(oMissCount), 255);
    wait_spawn(n, ms);
    run_active(0, -1, len, miss);
    check("sat_hold_miss", miss, 1);
    check("sat_hold_count", int'(oMissCount), 255);

    // Reset mid-ACTIVE
    iLevel = 3'd1;
    wait_spawn(n, ms);
    repeat (3) step();
    check("prerst_active", int'(oActive), 1);
    Reset = 1'b1;
    step();
    check("mrst_poner",  int'(oPonerTopo), 0);
    check("mrst_active", int'(oActive),    0);
    check("mrst_miss",   int'(oMiss),      0);
    check("mrst_celda",  int'(oCelda),     0);
    check("mrst_count",  int'(oMissCount), 0);
    m_cnt = 0;
    m_prev = 4'd0;
    iRand = 4'd0;
    Reset = 1'b0;
    wait_spawn(n, ms);
    check("postrst_delay", n, 1 + GAP * TD);
    exp_c = int'(model_celda(4'd0, m_prev));
    check("postrst_celda", int'(oCelda), exp_c);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
